// File: rtl/rob_ctrl_if.sv
// Reorder-buffer control interface: dispatch allocation, completion writeback,
// in-order commit, operand lookup and occupancy status.
// slave = the ROB sequencer, master = the surrounding pipeline.
interface rob_ctrl_if #(
  parameter int PTR_W  = 3,
  parameter int DATA_W = 32
);
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [DATA_W-1:0] alloc_cell;
  logic [PTR_W-1:0]  alloc_tag;
  logic              cmpl_valid;
  logic [PTR_W-1:0]  cmpl_tag;
  logic [DATA_W-1:0] cmpl_cell;
  logic              commit_valid;
  logic              commit_ready;
  logic [PTR_W-1:0]  commit_tag;
  logic [DATA_W-1:0] commit_cell;
  logic [PTR_W-1:0]  lookup_tag;
  logic [DATA_W-1:0] lookup_cell;
  logic              lookup_done;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;

  modport slave (
    input  flush, alloc_valid, alloc_cell, cmpl_valid, cmpl_tag, cmpl_cell,
           commit_ready, lookup_tag,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_cell,
           lookup_cell, lookup_done, count, full, empty
  );

  modport master (
    output flush, alloc_valid, alloc_cell, cmpl_valid, cmpl_tag, cmpl_cell,
           commit_ready, lookup_tag,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_cell,
           lookup_cell, lookup_done, count, full, empty
  );
endinterface

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer sequencer. Owns head/tail/occupancy and per-entry
// done bits and maps allocation, completion, commit and lookup onto the
// external storage array's two write and two read ports.
// Optional feature macro: QU_ROB_CTRL_STATS_EN adds commit and full-stall
// statistics counters (cleared by rst only, not by flush).
module rob_ctrl #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  rob_ctrl_if.slave         bus,
  output logic              rob_wr1_en_o,
  output logic [PTR_W-1:0]  rob_wr1_addr_o,
  output logic [DATA_W-1:0] rob_wr1_in_o,
  output logic              rob_wr2_en_o,
  output logic [PTR_W-1:0]  rob_wr2_addr_o,
  output logic [DATA_W-1:0] rob_wr2_in_o,
  output logic [PTR_W-1:0]  rob_rd1_addr_o,
  input  logic [DATA_W-1:0] rob_rd1_out_i,
  output logic [PTR_W-1:0]  rob_rd2_addr_o,
  input  logic [DATA_W-1:0] rob_rd2_out_i
`ifdef QU_ROB_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_commits_o,
  output logic [31:0]       stat_full_stalls_o
`endif
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic full_w;
  logic empty_w;
  logic alloc_ready_w;
  logic alloc_fire;
  logic cmpl_acc;
  logic commit_valid_w;
  logic commit_fire;

  // An entry is live when its distance from head (mod DEPTH) is below count.
  function automatic logic is_live(input logic [PTR_W-1:0] tag,
                                   input logic [PTR_W-1:0] head,
                                   input logic [PTR_W:0]   cnt);
    logic [PTR_W-1:0] off;
    off = tag - head;
    return ({1'b0, off} < cnt);
  endfunction

  // Status is forced to the empty view while reset is asserted.
  assign full_w  = rst && (count_q == DEPTH_C);
  assign empty_w = !rst || (count_q == '0);

  // Allocation never depends on commit_ready: a full buffer stays closed
  // for the cycle even when the head is retiring.
  assign alloc_ready_w  = rst && !full_w && !bus.flush;
  assign alloc_fire     = bus.alloc_valid && alloc_ready_w;
  assign cmpl_acc       = rst && !bus.flush && bus.cmpl_valid &&
                          is_live(bus.cmpl_tag, head_q, count_q);
  assign commit_valid_w = rst && !empty_w && done_q[head_q] && !bus.flush;
  assign commit_fire    = commit_valid_w && bus.commit_ready;

  assign bus.alloc_ready  = alloc_ready_w;
  assign bus.alloc_tag    = tail_q;
  assign bus.commit_valid = commit_valid_w;
  assign bus.commit_tag   = head_q;
  assign bus.commit_cell  = rob_rd1_out_i;
  assign bus.lookup_cell  = rob_rd2_out_i;
  assign bus.lookup_done  = rst && is_live(bus.lookup_tag, head_q, count_q) &&
                            done_q[bus.lookup_tag];
  assign bus.count        = rst ? count_q : '0;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;

  assign rob_wr1_en_o   = alloc_fire;
  assign rob_wr1_addr_o = tail_q;
  assign rob_wr1_in_o   = bus.alloc_cell;
  assign rob_wr2_en_o   = cmpl_acc;
  assign rob_wr2_addr_o = bus.cmpl_tag;
  assign rob_wr2_in_o   = bus.cmpl_cell;
  assign rob_rd1_addr_o = head_q;
  assign rob_rd2_addr_o = bus.lookup_tag;

  // Next-state: flush wins; otherwise alloc, completion and commit all apply.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else begin
      if (alloc_fire) begin
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + 1'b1;
      end
      if (cmpl_acc) begin
        done_d[bus.cmpl_tag] = 1'b1;
      end
      // Clear after the completion set so a retiring head slot is left clean.
      if (commit_fire) begin
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef QU_ROB_CTRL_STATS_EN
  logic [31:0] stat_commits_q;
  logic [31:0] stat_full_stalls_q;

  // Free-running statistics; flush deliberately leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_commits_q     <= '0;
      stat_full_stalls_q <= '0;
    end else begin
      if (commit_fire) begin
        stat_commits_q <= stat_commits_q + 32'd1;
      end
      if (bus.alloc_valid && full_w) begin
        stat_full_stalls_q <= stat_full_stalls_q + 32'd1;
      end
    end
  end

  assign stat_commits_o     = stat_commits_q;
  assign stat_full_stalls_o = stat_full_stalls_q;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: directed scenarios followed by random traffic, checked
// against a queue-based model of the buffer and a shadow of the storage array.
module tb_rob_ctrl;
  localparam int D  = 8;
  localparam int PW = 3;
  localparam int DW = 16;

  logic clk;
  logic rst;

  rob_ctrl_if #(.PTR_W(PW), .DATA_W(DW)) bus ();

  logic          wr1_en, wr2_en;
  logic [PW-1:0] wr1_addr, wr2_addr, rd1_addr, rd2_addr;
  logic [DW-1:0] wr1_in, wr2_in, rd1_out, rd2_out;
`ifdef QU_ROB_CTRL_STATS_EN
  logic [31:0]   st_commits, st_stalls;
`endif

  rob_ctrl #(.DEPTH(D), .PTR_W(PW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .rob_wr1_en_o   (wr1_en),
    .rob_wr1_addr_o (wr1_addr),
    .rob_wr1_in_o   (wr1_in),
    .rob_wr2_en_o   (wr2_en),
    .rob_wr2_addr_o (wr2_addr),
    .rob_wr2_in_o   (wr2_in),
    .rob_rd1_addr_o (rd1_addr),
    .rob_rd1_out_i  (rd1_out),
    .rob_rd2_addr_o (rd2_addr),
    .rob_rd2_out_i  (rd2_out)
`ifdef QU_ROB_CTRL_STATS_EN
    ,
    .stat_commits_o     (st_commits),
    .stat_full_stalls_o (st_stalls)
`endif
  );

  // Storage array driven by the DUT's ports.
  logic [DW-1:0] arr [D];
  always @(posedge clk) begin
    if (wr1_en) arr[wr1_addr] <= wr1_in;
    if (wr2_en) arr[wr2_addr] <= wr2_in;
  end
  assign rd1_out = arr[rd1_addr];
  assign rd2_out = arr[rd2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of live entries, oldest first.
  typedef struct { int tag; bit done; } ent_t;
  ent_t          q[$];
  int            m_head;
  logic [DW-1:0] smem [D];
  bit            sval [D];
  int unsigned   m_commits, m_stalls;

  int vectors;
  int miscompares;

  function automatic int find(input int t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle,
  // then advance the model at the edge.
  task automatic step(input bit rs, input bit fl, input bit av, input logic [DW-1:0] acell,
                      input bit cv, input int ctag, input logic [DW-1:0] ccell,
                      input bit cr, input int ltag);
    int  cnt, tail, ci, li;
    bit  e_ar, a_fire, c_acc, e_cv, c_fire, e_ld;
    rst              = rs;
    bus.flush        = fl;
    bus.alloc_valid  = av;
    bus.alloc_cell   = acell;
    bus.cmpl_valid   = cv;
    bus.cmpl_tag     = PW'(ctag);
    bus.cmpl_cell    = ccell;
    bus.commit_ready = cr;
    bus.lookup_tag   = PW'(ltag);
    @(negedge clk);
    cnt    = q.size();
    tail   = (m_head + cnt) % D;
    ci     = find(ctag);
    li     = find(ltag);
    e_ar   = rs && (cnt < D) && !fl;
    a_fire = av && e_ar;
    c_acc  = rs && !fl && cv && (ci >= 0);
    e_cv   = rs && (cnt > 0) && q[0].done && !fl;
    c_fire = e_cv && cr;
    e_ld   = rs && (li >= 0) && q[li].done;

    chk("alloc_ready", 32'(bus.alloc_ready), 32'(e_ar));
    chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
    chk("wr1_en", 32'(wr1_en), 32'(a_fire));
    chk("wr2_en", 32'(wr2_en), 32'(c_acc));
    chk("lookup_done", 32'(bus.lookup_done), 32'(e_ld));
    chk("empty", 32'(bus.empty), 32'(!rs || cnt == 0));
    chk("full", 32'(bus.full), 32'(rs && cnt == D));
    chk("rd2_addr", 32'(rd2_addr), 32'(ltag));
    assert (!(wr1_en && wr2_en && wr1_addr == wr2_addr)) else begin
      miscompares++;
      $error("FAIL port_collision: observed addr %0d on both ports expected distinct", wr1_addr);
    end
    vectors++;
    if (rs) begin
      chk("count", 32'(bus.count), 32'(cnt));
      chk("alloc_tag", 32'(bus.alloc_tag), 32'(tail));
      chk("commit_tag", 32'(bus.commit_tag), 32'(m_head));
      chk("rd1_addr", 32'(rd1_addr), 32'(m_head));
    end
    if (a_fire) begin
      chk("wr1_addr", 32'(wr1_addr), 32'(tail));
      chk("wr1_in", 32'(wr1_in), 32'(acell));
    end
    if (c_acc) begin
      chk("wr2_addr", 32'(wr2_addr), 32'(ctag));
      chk("wr2_in", 32'(wr2_in), 32'(ccell));
    end
    if (e_cv) chk("commit_cell", 32'(bus.commit_cell), 32'(smem[m_head]));
    if (sval[ltag]) chk("lookup_cell", 32'(bus.lookup_cell), 32'(smem[ltag]));
`ifdef QU_ROB_CTRL_STATS_EN
    if (rs) begin
      chk("stat_commits", st_commits, m_commits);
      chk("stat_full_stalls", st_stalls, m_stalls);
    end
`endif

    @(posedge clk);
    if (!rs) begin
      q.delete();
      m_head    = 0;
      m_commits = 0;
      m_stalls  = 0;
    end else begin
      if (c_fire) m_commits++;
      if (av && cnt == D) m_stalls++;
      if (fl) begin
        q.delete();
        m_head = 0;
      end else begin
        if (c_acc) begin
          q[ci].done = 1'b1;
          smem[ctag] = ccell;
          sval[ctag] = 1'b1;
        end
        if (a_fire) begin
          q.push_back('{tag: tail, done: 1'b0});
          smem[tail] = acell;
          sval[tail] = 1'b1;
        end
        if (c_fire) begin
          void'(q.pop_front());
          m_head = (m_head + 1) % D;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input bit cr, input int ltag);
    step(1, 0, 0, '0, 0, 0, '0, cr, ltag);
  endtask

  task automatic alloc(input logic [DW-1:0] c);
    step(1, 0, 1, c, 0, 0, '0, 0, 0);
  endtask

  task automatic cmpl(input int t, input logic [DW-1:0] c, input bit cr);
    step(1, 0, 0, '0, 1, t, c, cr, t);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_head      = 0;
    m_commits   = 0;
    m_stalls    = 0;
    for (int i = 0; i < D; i++) begin
      smem[i] = '0;
      sval[i] = 1'b0;
    end
    rst = 1'b0;
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_cell = '0;
    bus.cmpl_valid = 1'b0; bus.cmpl_tag = '0; bus.cmpl_cell = '0;
    bus.commit_ready = 1'b0; bus.lookup_tag = '0;
    @(posedge clk); #1;

    // Reset, then three allocations.
    step(0, 0, 1, 16'h1111, 1, 0, 16'h0, 1, 0);
    step(0, 0, 0, '0, 0, 0, '0, 0, 0);
    alloc(16'hA0A0);
    alloc(16'hB0B0);
    alloc(16'hC0C0);
    idle(0, 2);

    // Out-of-order completion, then in-order commit.
    cmpl(1, 16'hB111, 0);
    cmpl(0, 16'hA000, 0);
    idle(1, 0);
    idle(1, 1);
    idle(1, 2);

    // Fill from a clean state, then commit while full with alloc pending.
    step(0, 0, 0, '0, 0, 0, '0, 0, 0);
    for (int i = 0; i < D; i++) alloc(DW'(16'h2000 + i));
    step(1, 0, 1, 16'h2F00, 0, 0, '0, 0, 0);
    cmpl(0, 16'h3000, 0);
    step(1, 0, 1, 16'h2F01, 0, 0, '0, 1, 0);
    step(1, 0, 1, 16'h2F02, 0, 0, '0, 0, 0);
    idle(0, 0);

    // Flush, then completion to a non-live tag while empty.
    step(1, 1, 1, 16'h4444, 1, 3, 16'h5555, 1, 3);
    step(1, 0, 0, '0, 1, 5, 16'h5A5A, 0, 5);
    idle(0, 5);

    // Four live entries, flush with alloc_valid high.
    for (int i = 0; i < 4; i++) alloc(DW'(16'h6000 + i));
    cmpl(2, 16'h6222, 0);
    step(1, 1, 1, 16'h6FFF, 0, 0, '0, 0, 2);
    idle(0, 0);

    // Mid-stream reset.
    alloc(16'h7000);
    cmpl(0, 16'h7777, 0);
    step(0, 0, 1, 16'h7001, 0, 0, '0, 1, 0);
    idle(1, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit rs, fl, av, cv, cr;
      int ct;
      rs = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 39) == 0);
      av = ($urandom_range(0, 2) != 0);
      cv = ($urandom_range(0, 1) != 0);
      cr = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct = $urandom_range(0, D - 1);
      step(rs, fl, av, DW'($urandom), cv, ct, DW'($urandom), cr, $urandom_range(0, D - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
